pixel_deserializer_128bit: RTL
==============================

Name: pixel_deserializer_128bit

Overview:
- Serial-in, parallel-out counterpart of the 128-bit pixel shifter. Collects a serial pixel bit stream, MSB first, into WIDTH-bit words.
- Sits on the capture/readback side of the pixel path: assembles glyph/row bitmaps from a serial source and hands them to a consumer over a valid/ready interface.
- Double-buffered: an assembly shift register plus an output holding register, so reception continues while a finished word waits for the consumer.
- A flush request emits a partial word.

Parameters:
- WIDTH, 128, bits per word; must be ≥2.
- CNT_W, 8, width of bit counters; must hold the value WIDTH (2^CNT_W > WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- in_bit  input  1  serial pixel bit
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  block accepts in_bit this cycle; a bit is accepted when in_valid && in_ready
- flush  input  1  one-cycle request to emit the current partial word
- out_word  output  WIDTH  assembled word; the first received bit is at out_word[WIDTH-1]
- out_bits  output  CNT_W  number of valid bits in out_word (WIDTH for full words, 1..WIDTH-1 for a flushed word)
- out_valid  output  1  out_word/out_bits valid; held stable until accepted
- out_ready  input  1  consumer accepts the word when out_valid && out_ready

Behaviour:
- Reset (reset==0 at a posedge) clears everything:
  - asm register, asm_cnt, out_word, out_bits, out_valid and the flush_pend flag all go to 0.
  - in_ready is 1 in the cycle after reset.
  - Reset mid-word or mid-hold discards all data; no partial output is produced.
- Assembly:
  - On each accepted bit, asm <= {asm[WIDTH-2:0], in_bit} and asm_cnt increments.
  - The bit accepted in the same cycle as a transfer out of a full asm starts the new word: asm_cnt=1, asm[0]=in_bit.
- States, encoded by asm_cnt and flush_pend:
  - FILL: asm_cnt < WIDTH.
  - FULL: asm_cnt == WIDTH.
  - FLUSH_PEND: flush_pend == 1.
- out_free = !out_valid || out_ready (combinational).
- Transfer: in any cycle where asm_cnt == WIDTH and out_free:
  - next cycle out_word = asm, out_bits = WIDTH, out_valid = 1, asm_cnt = 0 (or 1 if a bit is accepted this cycle).
- Latency: WIDTH-th bit accepted at cycle N with out_free → asm FULL at N+1, out_valid = 1 at N+2.
- Handshake and backpressure:
  - in_ready = !flush_pend && (asm_cnt < WIDTH || out_free). This depends combinationally on out_ready.
  - With out_ready held 1 and in_valid held 1, the stream never stalls; a word emerges every WIDTH cycles.
  - While out_valid=1 and out_ready=0, out_word/out_bits must not change.
  - out_valid drops the cycle after acceptance unless a new transfer happens the same cycle (back-to-back words allowed).
- Flush:
  - Rising of flush with effective count k > 0 sets flush_pend. Effective count k is asm_cnt including any bit accepted that same cycle.
  - With k == 0, flush is ignored.
  - Flush while FULL is treated as a normal full transfer; flush_pend is not set.
  - While flush_pend is set, in_ready = 0. When out_free:
    - out_word = asm << (WIDTH-k), left-justified with zero LSBs.
    - out_bits = k, out_valid = 1.
    - asm_cnt = 0, asm = 0, flush_pend = 0.
  - Flush asserted while flush_pend is already set has no additional effect.
- Widths: asm_cnt saturates logically at WIDTH (it never exceeds it, because in_ready gates input). No arithmetic overflow is permitted.
- Simultaneous events, in priority order:
  1. reset
  2. transfer/flush execution
  3. bit accept (shifts into the freshly cleared or continuing asm)
  4. out acceptance, which clears out_valid unless reloaded.

Test Plan:
- Reset, then feed 128 bits as a single 1 followed by 127 zeros, out_ready=1 → out_valid at the 2nd cycle after the last bit, out_word=1<<127, out_bits=128; in_ready stays 1 throughout.
- Stream 384 bits of alternating 1,0 with in_valid=1 and out_ready=1 → three words of 128'hAAAA…AAAA at 128-cycle intervals; in_ready never drops.
- Hold out_ready=0 and send 256 bits → first word held stable with out_valid=1; second word fills asm; in_ready=0 after bit 256; raise out_ready → word 1 then word 2 delivered, in_ready returns to 1.
- Send 5 bits 1,0,1,1,0, then pulse flush → out_word = 5'b10110 followed by 123 zeros (128'hB0000…0), out_bits=5; empty flush next → no output.
- Send 40 bits, hold reset=0 one cycle → out_valid=0, in_ready=1; the next 128 bits form a clean word with no leftover bits.
- Pulse flush in the same cycle as the 1st accepted bit (in_bit=1) while out_valid=1 and out_ready=0 → in_ready=0 until out_ready=1; then out_word=128'h8000…0, out_bits=1.

Source files
------------

// File: rtl/pixel_deserializer_128bit_if.sv
// Bus bundle for the pixel deserializer.
// The serial input side and the word output side travel together.
interface pixel_deserializer_128bit_if #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 8
) ();
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] out_word;
  logic [CNT_W-1:0] out_bits;
  logic             out_valid;
  logic             out_ready;

  // Stimulus source and word consumer.
  modport master (
    output in_bit, in_valid, flush, out_ready,
    input  in_ready, out_word, out_bits, out_valid
  );

  // The deserializer itself.
  modport slave (
    input  in_bit, in_valid, flush, out_ready,
    output in_ready, out_word, out_bits, out_valid
  );
endinterface

// File: rtl/pixel_deserializer_128bit.sv
// Serial-in, parallel-out pixel deserializer.
// Bits arrive MSB first and are assembled into WIDTH-bit words.
// An assembly register feeds an output holding register, so reception
// continues while a finished word waits for the consumer.
// A flush emits the current partial word left-justified.
module pixel_deserializer_128bit #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 8
) (
  input logic                     clock,
  input logic                     reset,
  pixel_deserializer_128bit_if.slave bus
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  logic [WIDTH-1:0] asm_q;
  logic [CNT_W-1:0] asm_cnt;
  logic             flush_pend;
  logic [WIDTH-1:0] out_word_q;
  logic [CNT_W-1:0] out_bits_q;
  logic             out_valid_q;

  logic             out_free;
  logic             in_ready;
  logic             accept;
  logic             asm_full;
  logic             transfer;
  logic             flush_exec;
  logic             flush_set;
  logic [WIDTH-1:0] asm_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] flushed_word;

  assign out_free   = !out_valid_q || bus.out_ready;
  assign asm_full   = (asm_cnt == FULL_CNT);
  assign in_ready   = !flush_pend && (!asm_full || out_free);
  assign accept     = bus.in_valid && in_ready;
  assign transfer   = asm_full && out_free;
  assign flush_exec = flush_pend && out_free;

  assign bus.in_ready  = in_ready;
  assign bus.out_word  = out_word_q;
  assign bus.out_bits  = out_bits_q;
  assign bus.out_valid = out_valid_q;

  // Next assembly state: a transfer or flush empties asm first, then any
  // accepted bit shifts into the cleared or continuing register.
  always_comb begin
    asm_nxt      = asm_q;
    cnt_nxt      = asm_cnt;
    flushed_word = asm_q << (FULL_CNT - asm_cnt);
    if (transfer || flush_exec) begin
      asm_nxt = '0;
      cnt_nxt = '0;
    end
    if (accept) begin
      asm_nxt = {asm_nxt[WIDTH-2:0], bus.in_bit};
      cnt_nxt = cnt_nxt + 1'b1;
    end
    // cnt_nxt is the effective count k here, since flush_exec cannot coexist
    // with a new flush and a full asm is excluded; k == WIDTH simply
    // completes a normal word.
    flush_set = bus.flush && !flush_pend && !asm_full &&
                (cnt_nxt != '0) && (cnt_nxt != FULL_CNT);
  end

  // Registered state: output holding register, assembly register, flush flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      asm_q       <= '0;
      asm_cnt     <= '0;
      flush_pend  <= 1'b0;
      out_word_q  <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (transfer) begin
        out_word_q  <= asm_q;
        out_bits_q  <= FULL_CNT;
        out_valid_q <= 1'b1;
      end else if (flush_exec) begin
        out_word_q  <= flushed_word;
        out_bits_q  <= asm_cnt;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (flush_exec) begin
        flush_pend <= 1'b0;
      end else if (flush_set) begin
        flush_pend <= 1'b1;
      end

      asm_q   <= asm_nxt;
      asm_cnt <= cnt_nxt;
    end
  end

endmodule
